// File: rtl/uart_rx_framer.sv
// UART receive framer: synchronizes the serial line, recovers start/data/
// parity/stop by mid-bit sampling, and presents each byte through a
// valid/ready holding register with parity, framing and overrun flags.
module uart_rx_framer #(
    parameter int D_WIDTH      = 8,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_O_1   = 0,
    parameter int CLK_FREQ_MHZ = 50,
    parameter int BAUD_RATE    = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Rx,
    output logic [D_WIDTH-1:0] data_out,
    output logic               data_valid,
    input  logic               data_ready,
    output logic               parity_err,
    output logic               frame_err,
    output logic               overrun_err,
    output logic               busy
);

    localparam int CLKS_PER_BIT = (CLK_FREQ_MHZ * 1000000) / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(D_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t             state;
    logic               rx_m;
    logic               rx_s;
    logic [CNT_W-1:0]   bit_cnt;
    logic [IDX_W-1:0]   idx;
    logic [D_WIDTH-1:0] shift_reg;
    logic               par_bad;
    logic               stop_bad;
    logic               commit_pend;

    assign busy = (state != S_IDLE);

    // Two-flop synchronizer; resets to the idle (high) line level
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= Rx;
            rx_s <= rx_m;
        end
    end

    // Frame FSM plus holding-register commit/handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            idx         <= '0;
            shift_reg   <= '0;
            par_bad     <= 1'b0;
            stop_bad    <= 1'b0;
            commit_pend <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            commit_pend <= 1'b0;

            // Commit runs one cycle after the stop sample; shift_reg and par_bad
            // stay untouched until the next frame reaches DATA, so they are
            // read directly here instead of being copied at the stop sample.
            if (commit_pend) begin
                if (!data_valid || data_ready) begin
                    data_out   <= shift_reg;
                    parity_err <= par_bad;
                    frame_err  <= stop_bad;
                    data_valid <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state   <= S_START;
                        bit_cnt <= '0;
                    end
                end
                S_START: begin
                    if (bit_cnt == CNT_HALF) begin
                        bit_cnt <= '0;
                        idx     <= '0;
                        par_bad <= 1'b0;
                        state   <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_cnt == CNT_LAST) begin
                        bit_cnt   <= '0;
                        // Right shift: after D_WIDTH samples the first bit sits at the LSB
                        shift_reg <= {rx_s, shift_reg[D_WIDTH-1:1]};
                        if (idx == IDX_LAST) begin
                            state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (bit_cnt == CNT_LAST) begin
                        bit_cnt <= '0;
                        par_bad <= ((^shift_reg) ^ rx_s) != (PARITY_O_1 != 0);
                        state   <= S_STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_cnt == CNT_LAST) begin
                        bit_cnt     <= '0;
                        stop_bad    <= !rx_s;
                        commit_pend <= 1'b1;
                        state       <= rx_s ? S_IDLE : S_BREAK;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer at 50 clocks per bit, 8E1 framing, plus
// an odd-parity instance sharing the same serial line.
module tb_uart_rx_framer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       rdy = 1'b0;
    logic       rdy_odd = 1'b0;

    logic [7:0] data_out, data_out_odd;
    logic       data_valid, data_valid_odd;
    logic       parity_err, parity_err_odd;
    logic       frame_err, frame_err_odd;
    logic       overrun_err, overrun_err_odd;
    logic       busy, busy_odd;

    int checks = 0;
    int errors = 0;
    int ovr_cnt = 0;
    logic [9:0] got_q[$];

    always #5 clk = ~clk;

    uart_rx_framer #(.D_WIDTH(8), .PARITY_EN(1), .PARITY_O_1(0),
                     .CLK_FREQ_MHZ(50), .BAUD_RATE(1000000)) dut (
        .clk(clk), .rst(rst), .Rx(rx),
        .data_out(data_out), .data_valid(data_valid), .data_ready(rdy),
        .parity_err(parity_err), .frame_err(frame_err),
        .overrun_err(overrun_err), .busy(busy)
    );

    uart_rx_framer #(.D_WIDTH(8), .PARITY_EN(1), .PARITY_O_1(1),
                     .CLK_FREQ_MHZ(50), .BAUD_RATE(1000000)) dut_odd (
        .clk(clk), .rst(rst), .Rx(rx),
        .data_out(data_out_odd), .data_valid(data_valid_odd), .data_ready(rdy_odd),
        .parity_err(parity_err_odd), .frame_err(frame_err_odd),
        .overrun_err(overrun_err_odd), .busy(busy_odd)
    );

    // Record accepted words {frame_err, parity_err, data} and overrun pulses
    always @(posedge clk) begin
        if (!rst && data_valid && rdy) got_q.push_back({frame_err, parity_err, data_out});
        if (!rst && overrun_err) ovr_cnt = ovr_cnt + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One frame: start, 8 data bits LSB first, parity, stop; 50 clocks each
    task automatic send_frame(input logic [7:0] d, input logic p, input logic stp);
        logic [10:0] bits;
        bits = {stp, p, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk) rx = bits[i];
            repeat (49) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", data_valid); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", data_out); end
        checks++; if ({parity_err, frame_err, overrun_err, busy} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b exp 0000", {parity_err, frame_err, overrun_err, busy}); end
        @(negedge clk) rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_single;
        send_frame(8'h48, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        checks++; if (data_out !== 8'h48) begin errors++; $display("FAIL single_data got %h exp 48", data_out); end
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", data_valid); end
        checks++; if ({parity_err, frame_err} !== 2'b00) begin
            errors++; $display("FAIL single_flags got %b exp 00", {parity_err, frame_err}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b exp 0", busy); end
        rdy = 1'b1;
        @(negedge clk) rdy = 1'b0;
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL single_clear got %b exp 0", data_valid); end
    endtask

    task automatic test_back_to_back;
        int base;
        int ovr_base;
        logic [9:0] exp_w[3];
        exp_w[0] = {2'b00, 8'h48};
        exp_w[1] = {2'b00, 8'h69};
        exp_w[2] = {2'b00, 8'h21};
        base = got_q.size();
        ovr_base = ovr_cnt;
        rdy = 1'b1;
        send_frame(8'h48, 1'b0, 1'b1);
        send_frame(8'h69, 1'b0, 1'b1);
        send_frame(8'h21, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        rdy = 1'b0;
        checks++; if (got_q.size() - base != 3) begin
            errors++; $display("FAIL b2b_count got %0d exp 3", got_q.size() - base); end
        else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (got_q[base+i] !== exp_w[i]) begin
                    errors++; $display("FAIL b2b_word%0d got %h exp %h", i, got_q[base+i], exp_w[i]); end
            end
        end
        checks++; if (ovr_cnt != ovr_base) begin
            errors++; $display("FAIL b2b_overrun got %0d exp 0", ovr_cnt - ovr_base); end
    endtask

    task automatic test_parity;
        @(negedge clk) rdy_odd = 1'b1;
        @(negedge clk) rdy_odd = 1'b0;
        send_frame(8'h07, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        checks++; if (data_out !== 8'h07) begin errors++; $display("FAIL par_data got %h exp 07", data_out); end
        checks++; if ({data_valid, parity_err, frame_err} !== 3'b110) begin
            errors++; $display("FAIL par_even got %b exp 110", {data_valid, parity_err, frame_err}); end
        checks++; if (data_out_odd !== 8'h07) begin errors++; $display("FAIL par_odd_data got %h exp 07", data_out_odd); end
        checks++; if ({data_valid_odd, parity_err_odd, frame_err_odd} !== 3'b100) begin
            errors++; $display("FAIL par_odd got %b exp 100", {data_valid_odd, parity_err_odd, frame_err_odd}); end
        @(negedge clk) rdy = 1'b1;
        @(negedge clk) rdy = 1'b0;
    endtask

    task automatic test_glitch;
        @(negedge clk) rx = 1'b0;
        repeat (8) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_start_busy got %b exp 1", busy); end
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if ({busy, data_valid} !== 2'b00) begin
            errors++; $display("FAIL glitch_idle got %b exp 00", {busy, data_valid}); end
    endtask

    task automatic test_break;
        int ovr_base;
        ovr_base = ovr_cnt;
        send_frame(8'h3F, 1'b0, 1'b0);
        checks++; if ({data_valid, parity_err, frame_err} !== 3'b101) begin
            errors++; $display("FAIL brk_flags got %b exp 101", {data_valid, parity_err, frame_err}); end
        checks++; if (data_out !== 8'h3F) begin errors++; $display("FAIL brk_data got %h exp 3f", data_out); end
        repeat (200) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL brk_hold_busy got %b exp 1", busy); end
        rx = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL brk_release_busy got %b exp 0", busy); end
        repeat (100) @(negedge clk);
        checks++; if ({data_valid, data_out} !== {1'b1, 8'h3F} || ovr_cnt != ovr_base) begin
            errors++; $display("FAIL brk_no_second got v=%b d=%h ovr=%0d exp v=1 d=3f ovr=0",
                               data_valid, data_out, ovr_cnt - ovr_base); end
        @(negedge clk) rdy = 1'b1;
        @(negedge clk) rdy = 1'b0;
    endtask

    task automatic test_overrun;
        int ovr_base;
        ovr_base = ovr_cnt;
        send_frame(8'h6F, 1'b0, 1'b1);
        send_frame(8'h75, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        checks++; if ({data_valid, data_out} !== {1'b1, 8'h6F}) begin
            errors++; $display("FAIL ovr_hold got v=%b d=%h exp v=1 d=6f", data_valid, data_out); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL ovr_par got %b exp 0", parity_err); end
        checks++; if (ovr_cnt - ovr_base != 1) begin
            errors++; $display("FAIL ovr_pulses got %0d exp 1", ovr_cnt - ovr_base); end
        // Commit edge is the 529th rising edge after the start-bit falling edge
        ovr_base = ovr_cnt;
        fork
            send_frame(8'h55, 1'b0, 1'b1);
            begin
                @(negedge clk);
                repeat (528) @(posedge clk);
                @(negedge clk) rdy = 1'b1;
                @(negedge clk) rdy = 1'b0;
                checks++; if ({data_valid, data_out} !== {1'b1, 8'h55}) begin
                    errors++; $display("FAIL same_cycle_load got v=%b d=%h exp v=1 d=55", data_valid, data_out); end
            end
        join
        checks++; if (ovr_cnt != ovr_base) begin
            errors++; $display("FAIL same_cycle_overrun got %0d exp 0", ovr_cnt - ovr_base); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        d = 8'h55;
        @(negedge clk) rx = 1'b0;
        repeat (49) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk) rx = d[i];
            repeat (49) @(negedge clk);
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", busy); end
        @(negedge clk) begin rst = 1'b1; rx = 1'b1; end
        @(negedge clk) rst = 1'b0;
        checks++; if ({data_valid, data_out, parity_err, frame_err, overrun_err, busy} !== 13'h0) begin
            errors++; $display("FAIL mid_reset_outs got v=%b d=%h p=%b f=%b o=%b b=%b exp all 0",
                               data_valid, data_out, parity_err, frame_err, overrun_err, busy); end
        repeat (100) @(negedge clk);
        checks++; if ({data_valid, busy} !== 2'b00) begin
            errors++; $display("FAIL mid_after got %b exp 00", {data_valid, busy}); end
        send_frame(8'h55, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        checks++; if ({data_valid, parity_err, frame_err, data_out} !== {3'b100, 8'h55}) begin
            errors++; $display("FAIL mid_clean got v=%b p=%b f=%b d=%h exp v=1 p=0 f=0 d=55",
                               data_valid, parity_err, frame_err, data_out); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_parity;
        test_glitch;
        test_break;
        test_overrun;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
